// File: rtl/uart_txrx_core.sv
// rtl/uart_txrx_core.sv - 8N1 UART serialiser/deserialiser with TX and RX FIFOs on a shared 16x baud tick
`timescale 1ns/1ps

module uart_txrx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic [7:0] wr_data,
  input  logic       push,
  input  logic       pop,
  output logic [7:0] rd_data,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wp;
  logic [AW:0] rp;
  logic        full;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wp == rp);
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO still takes a coincident push
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rp[AW-1:0]];

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (do_push) begin
        mem[wp[AW-1:0]] <= wr_data;
        wp              <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
    end
  end
endmodule

module uart_txrx_core #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic [7:0] tx_data,
  input  logic       tx_wr,
  output logic       tx_empty,
  output logic       tx_busy,
  output logic       TX,
  output logic [7:0] rx_data,
  input  logic       rx_rd,
  output logic       rx_valid,
  input  logic       RX
);
  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int BW  = $clog2(DIV);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [BW-1:0] baud_cnt;
  logic          tick;

  assign tick = (baud_cnt == BW'(DIV - 1));

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET)    baud_cnt <= '0;
    else if (tick) baud_cnt <= '0;
    else           baud_cnt <= baud_cnt + 1'b1;
  end

  state_t     tx_state;
  logic [4:0] tx_tcnt;
  logic [2:0] tx_bit;
  logic [7:0] tx_shift;
  logic [7:0] tx_head;
  logic       tx_pop;

  assign tx_pop = (tx_state == S_IDLE) && !tx_empty;

  uart_txrx_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .wr_data (tx_data),
    .push    (tx_wr),
    .pop     (tx_pop),
    .rd_data (tx_head),
    .empty   (tx_empty)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      tx_state <= S_IDLE;
      tx_tcnt  <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      TX       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      case (tx_state)
        S_IDLE: if (tx_pop) begin
          tx_shift <= tx_head;
          // A tick on the entry edge counts as the first start-bit tick
          tx_tcnt  <= {4'b0, tick};
          tx_bit   <= '0;
          TX       <= 1'b0;
          tx_busy  <= 1'b1;
          tx_state <= S_START;
        end
        S_START: if (tick) begin
          if (tx_tcnt == 5'd16) begin
            tx_tcnt  <= '0;
            TX       <= tx_shift[0];
            tx_state <= S_DATA;
          end else tx_tcnt <= tx_tcnt + 1'b1;
        end
        S_DATA: if (tick) begin
          if (tx_tcnt == 5'd15) begin
            tx_tcnt <= '0;
            if (tx_bit == 3'd7) begin
              TX       <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              TX       <= tx_shift[1];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_bit   <= tx_bit + 1'b1;
            end
          end else tx_tcnt <= tx_tcnt + 1'b1;
        end
        S_STOP: if (tick) begin
          if (tx_tcnt == 5'd15) begin
            tx_tcnt  <= '0;
            tx_busy  <= 1'b0;
            tx_state <= S_IDLE;
          end else tx_tcnt <= tx_tcnt + 1'b1;
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  logic       rx_sync1;
  logic       rx_s;
  state_t     rx_state;
  logic [3:0] rx_tcnt;
  logic [2:0] rx_bit;
  logic [7:0] rx_shift;
  logic       rx_push;
  logic       rx_empty;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rx_sync1 <= 1'b1;
      rx_s     <= 1'b1;
    end else begin
      rx_sync1 <= RX;
      rx_s     <= rx_sync1;
    end
  end

  // Stop-bit sample edge; a low stop bit is a framing error and the byte is dropped
  assign rx_push = (rx_state == S_STOP) && tick && (rx_tcnt == 4'd15) && rx_s;

  uart_txrx_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .wr_data (rx_shift),
    .push    (rx_push),
    .pop     (rx_rd),
    .rd_data (rx_data),
    .empty   (rx_empty)
  );

  assign rx_valid = !rx_empty;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      rx_state <= S_IDLE;
      rx_tcnt  <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        S_IDLE: if (!rx_s) begin
          rx_tcnt  <= '0;
          rx_state <= S_START;
        end
        S_START: if (tick) begin
          if (rx_tcnt == 4'd7) begin
            rx_tcnt  <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? S_IDLE : S_DATA;
          end else rx_tcnt <= rx_tcnt + 1'b1;
        end
        S_DATA: if (tick) begin
          if (rx_tcnt == 4'd15) begin
            rx_tcnt  <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= S_STOP;
            else                rx_bit   <= rx_bit + 1'b1;
          end else rx_tcnt <= rx_tcnt + 1'b1;
        end
        S_STOP: if (tick) begin
          if (rx_tcnt == 4'd15) begin
            rx_tcnt  <= '0;
            rx_state <= S_IDLE;
          end else rx_tcnt <= rx_tcnt + 1'b1;
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_txrx_core.sv
// tb/tb_uart_txrx_core.sv - randomized self-checking bench for uart_txrx_core against a queue-based line model
`timescale 1ns/1ps

module tb_uart_txrx_core;
  localparam int DIV   = 10;
  localparam int BITC  = 16 * DIV;
  localparam int DEPTH = 4;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_wr = 1'b0;
  logic       rx_rd = 1'b0;
  logic       RX = 1'b1;
  logic       tx_empty, tx_busy, TX, rx_valid;
  logic [7:0] rx_data;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc;
  logic [7:0]  rx_q[$];
  logic [7:0]  tx_exp[$];

  uart_txrx_core #(.CLK_HZ(1_600_000), .BAUD(10_000), .FIFO_DEPTH(DEPTH)) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .tx_data  (tx_data),
    .tx_wr    (tx_wr),
    .tx_empty (tx_empty),
    .tx_busy  (tx_busy),
    .TX       (TX),
    .rx_data  (rx_data),
    .rx_rd    (rx_rd),
    .rx_valid (rx_valid),
    .RX       (RX)
  );

  always #5 PCLK = ~PCLK;

  // Edges since reset release; the baud tick fires on edges where cyc % DIV == DIV-1 beforehand
  always @(posedge PCLK or posedge PRESET)
    if (PRESET) cyc <= 0;
    else        cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Decode one frame off TX; bit centres are placed assuming a start bit of 160..169 cycles
  task automatic tx_recv(output logic [7:0] b, output int slen, output int blen,
                         output int gap, output logic stopb);
    logic seen_hi;
    gap = 0; b = '0; slen = 0; blen = 0; stopb = 1'b0; seen_hi = 1'b0;
    while (TX !== 1'b0 && gap < 4000) begin
      @(negedge PCLK);
      gap++;
    end
    if (TX !== 1'b0) begin
      check("tx_start_timeout", {31'b0, TX}, 32'd0);
      return;
    end
    for (int c = 0; c < 2000; c++) begin
      if (!seen_hi && TX === 1'b0) slen++;
      else seen_hi = 1'b1;
      for (int i = 0; i < 8; i++) if (c == 244 + BITC * i) b[i] = TX;
      if (c == 244 + BITC * 8) stopb = TX;
      if (tx_busy !== 1'b1) break;
      blen++;
      @(negedge PCLK);
    end
  endtask

  // Stop bit is held only 100 cycles so a low stop bit cannot be mistaken for a new start bit
  task automatic rx_send(input logic [7:0] d, input logic stopb, input logic rd_at_push);
    int ticks;
    logic [9:0] fr;
    ticks = 0;
    fr = {stopb, d, 1'b0};
    for (int c = 0; c < 9 * BITC + 100 + 60; c++) begin
      @(negedge PCLK);
      RX = (c < 9 * BITC + 100) ? fr[c / BITC] : 1'b1;
      rx_rd = 1'b0;
      if (c > 2 && (cyc % DIV) == DIV - 1) begin
        ticks++;
        if (ticks == 152 && rd_at_push) rx_rd = 1'b1;
      end
    end
    if (rd_at_push && rx_q.size() > 0) void'(rx_q.pop_front());
    if (stopb && rx_q.size() < DEPTH) rx_q.push_back(d);
  endtask

  task automatic rx_drain(input string tag);
    while (rx_q.size() > 0) begin
      check({tag, "_valid"}, {31'b0, rx_valid}, 32'd1);
      check({tag, "_data"}, {24'b0, rx_data}, {24'b0, rx_q[0]});
      void'(rx_q.pop_front());
      rx_rd = 1'b1;
      @(negedge PCLK);
      rx_rd = 1'b0;
    end
    check({tag, "_empty"}, {31'b0, rx_valid}, 32'd0);
  endtask

  initial begin
    logic [7:0] b;
    logic       sb;
    int         slen, blen, gap, n, busy_seen;

    repeat (3) @(negedge PCLK);
    check("rst_tx", {31'b0, TX}, 32'd1);
    check("rst_tx_empty", {31'b0, tx_empty}, 32'd1);
    check("rst_tx_busy", {31'b0, tx_busy}, 32'd0);
    check("rst_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("rst_rx_data", {24'b0, rx_data}, 32'd0);
    PRESET = 1'b0;
    repeat (5) @(negedge PCLK);

    tx_data = 8'hA5; tx_wr = 1'b1;
    @(negedge PCLK);
    tx_wr = 1'b0;
    check("a5_empty_after_wr", {31'b0, tx_empty}, 32'd0);
    @(negedge PCLK);
    check("a5_empty_after_pop", {31'b0, tx_empty}, 32'd1);
    check("a5_busy", {31'b0, tx_busy}, 32'd1);
    check("a5_tx_low", {31'b0, TX}, 32'd0);
    tx_recv(b, slen, blen, gap, sb);
    check("a5_byte", {24'b0, b}, 32'hA5);
    check("a5_start_len_ok", {31'b0, (slen >= 160 && slen <= 169)}, 32'd1);
    check("a5_rest_len", blen - slen, 9 * BITC);
    check("a5_stop", {31'b0, sb}, 32'd1);

    // Burst writes: one byte goes to the shifter right away, DEPTH more fit in the FIFO
    for (int r = 0; r < 2; r++) begin
      n = (r == 0) ? 6 : $urandom_range(1, 7);
      tx_exp.delete();
      @(negedge PCLK);
      for (int k = 0; k < n; k++) begin
        tx_data = (r == 0) ? 8'(k + 1) : 8'($urandom);
        if (k < DEPTH + 1) tx_exp.push_back(tx_data);
        tx_wr = 1'b1;
        @(negedge PCLK);
      end
      tx_wr = 1'b0;
      while (tx_exp.size() > 0) begin
        tx_recv(b, slen, blen, gap, sb);
        check($sformatf("burst%0d_byte", r), {24'b0, b}, {24'b0, tx_exp[0]});
        check($sformatf("burst%0d_stop", r), {31'b0, sb}, 32'd1);
        check($sformatf("burst%0d_gap_ok", r), {31'b0, (gap <= 1)}, 32'd1);
        void'(tx_exp.pop_front());
      end
      busy_seen = 0;
      repeat (200) begin
        @(negedge PCLK);
        if (tx_busy !== 1'b0) busy_seen++;
      end
      check($sformatf("burst%0d_no_extra", r), busy_seen, 0);
      check($sformatf("burst%0d_empty", r), {31'b0, tx_empty}, 32'd1);
    end

    rx_send(8'h3C, 1'b1, 1'b0);
    rx_drain("rx_3c");

    @(negedge PCLK); RX = 1'b0;
    repeat (40) @(negedge PCLK);
    RX = 1'b1;
    repeat (200) @(negedge PCLK);
    check("rx_glitch", {31'b0, rx_valid}, 32'd0);

    rx_send(8'h55, 1'b0, 1'b0);
    check("rx_framing", {31'b0, rx_valid}, 32'd0);

    for (int k = 0; k < 5; k++) rx_send(8'(8'h10 + k), 1'b1, 1'b0);
    rx_drain("rx_overrun");

    for (int k = 0; k < DEPTH; k++) rx_send(8'($urandom), 1'b1, 1'b0);
    check("rx_simul_head", {24'b0, rx_data}, {24'b0, rx_q[0]});
    rx_send(8'($urandom), 1'b1, 1'b1);
    rx_drain("rx_simul");

    n = $urandom_range(1, 5);
    for (int k = 0; k < n; k++) rx_send(8'($urandom), ($urandom_range(0, 4) != 0), 1'b0);
    rx_drain("rx_rand");

    @(negedge PCLK);
    tx_data = 8'h00; tx_wr = 1'b1; RX = 1'b0;
    @(negedge PCLK);
    tx_wr = 1'b0;
    repeat (600) @(negedge PCLK);
    check("rst_mid_tx_pre", {31'b0, TX}, 32'd0);
    #2 PRESET = 1'b1;
    #1 check("rst_mid_tx_async", {31'b0, TX}, 32'd1);
    RX = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    repeat (3) @(negedge PCLK);
    check("rst_mid_busy", {31'b0, tx_busy}, 32'd0);
    check("rst_mid_empty", {31'b0, tx_empty}, 32'd1);
    check("rst_mid_rx_valid", {31'b0, rx_valid}, 32'd0);
    check("rst_mid_tx_idle", {31'b0, TX}, 32'd1);
    tx_data = 8'($urandom); tx_wr = 1'b1;
    tx_exp.push_back(tx_data);
    @(negedge PCLK);
    tx_wr = 1'b0;
    tx_recv(b, slen, blen, gap, sb);
    check("rst_mid_next_byte", {24'b0, b}, {24'b0, tx_exp[0]});
    check("rst_mid_next_stop", {31'b0, sb}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_txrx_core.md
# uart_txrx_core

Serial engine behind the APB UART register interface: accepts bytes on `tx_data`/`tx_wr`, buffers them in a TX FIFO and serialises them as 8N1 frames on `TX`. It deserialises 8N1 frames from `RX` into an RX FIFO, presented to the register interface via `rx_data`/`rx_valid`/`rx_rd`. Instantiated inside the UART peripheral, directly downstream of the APB slave interface. Runs entirely on PCLK with a shared 16x-oversampling baud tick.

## Interface
- `CLK_HZ`, default 100_000_000, PCLK frequency in Hz.
- `BAUD`, default 9600, line rate. `DIV = CLK_HZ/(BAUD*16)` (integer division, must be ≥ 2).
- `FIFO_DEPTH`, default 4, entries per FIFO; power of two, ≥ 2.
- `PCLK  in  1  clock; all logic on rising edge.`
- `PRESET  in  1  reset, asynchronous, active-high.`
- `tx_data  in  8  byte to transmit; sampled when tx_wr=1.`
- `tx_wr  in  1  one-cycle push strobe into the TX FIFO.`
- `tx_empty  out  1  TX FIFO holds no entries.`
- `tx_busy  out  1  serialiser is mid-frame.`
- `TX  out  1  serial output, idle high.`
- `rx_data  out  8  head of the RX FIFO (first-word fall-through).`
- `rx_rd  in  1  one-cycle pop strobe for the RX FIFO.`
- `rx_valid  out  1  RX FIFO non-empty.`
- `RX  in  1  asynchronous serial input, idle high.`

## Operation
- Baud generator: counter 0..DIV-1; `tick` is asserted for one cycle when the counter is at DIV-1, then the counter wraps to 0. Free-running from reset.
- FIFOs: circular buffers with pointers of log2(FIFO_DEPTH)+1 bits; full and empty are derived from pointer MSB/LSB comparison.
  - Push when full: dropped, no state change.
  - Pop when empty: ignored.
  - Simultaneous push and pop when full: both occur.
  - Simultaneous push and pop when empty: push only.
- TX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: when the TX FIFO is non-empty, pop the head into the shift register and go to START. This does not wait for a tick.
  - START: drive `TX=0` for 16 ticks.
  - DATA: drive 8 bits LSB first, 16 ticks each.
  - STOP: drive `TX=1` for 16 ticks, then go to IDLE.
  - `tx_busy=1` in every state except IDLE.
  - Back-to-back frames: IDLE lasts exactly one cycle when the FIFO is non-empty.
- RX path: `RX` passes through a 2-FF synchronizer (reset value 1), giving `rx_s`.
- RX FSM: IDLE → START → DATA → STOP → IDLE.
  - IDLE: on `rx_s=0`, clear the tick counter and go to START.
  - START: after 8 ticks, if `rx_s=0` go to DATA; otherwise treat as a glitch and return to IDLE.
  - DATA: sample `rx_s` every 16 ticks, 8 times, shifting in LSB first.
  - STOP: after 16 ticks, sample `rx_s`. If 1, push the byte into the RX FIFO. If 0 (framing error), discard the byte. Either way go to IDLE.
  - The RX FIFO push is dropped if the FIFO is full (overrun; the oldest data is kept).
- Reset mid-frame: both FSMs return to IDLE and both FIFOs empty immediately. `TX` goes to 1 asynchronously.

## Timing
- Reset values: `TX=1`, `tx_empty=1`, `tx_busy=0`, `rx_valid=0`, `rx_data=8'h00`.
  - FIFO storage is reset to 0.
  - Baud counter, all FSM counters and the shift registers reset to 0.
- `tx_wr` at edge N (FIFO was empty): `tx_empty=0` after edge N. At edge N+1 the FSM pops, so `tx_empty=1` (if nothing else was queued), `tx_busy=1` and `TX=0`.
- Start bit length: 16 ticks counted from the first tick after entry, i.e. 16·DIV to 17·DIV−1 cycles. Every later bit is exactly 16·DIV cycles.
- Frame end: `tx_busy` falls in the same cycle that STOP exits.
- `rx_rd` at edge N: `rx_data`/`rx_valid` show the next entry after edge N. `rx_data` is stable while `rx_valid=1` and no pop occurs.
- RX byte visible: `rx_valid` rises 1 cycle after the stop-bit sample.
- RX input latency: 2 cycles of synchronizer delay from `RX` to `rx_s`.

## Test plan
Test parameters: CLK_HZ=1_600_000, BAUD=10_000 (DIV=10, 160 cycles/bit).
- Single TX byte: `tx_wr` with 8'hA5 → `TX` shows 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each bit 160 cycles (start bit 160–169). `tx_busy` is high for the whole frame. `tx_empty` returns to 1 one cycle after the write.
- TX overflow: 6 consecutive `tx_wr` of 8'h01..8'h06 with FIFO_DEPTH=4 → transmitted sequence is 01,02,03,04,05. Byte 01 was popped before the 5th write; 06 is dropped. No idle gap longer than 1 cycle between frames.
- RX loopback: drive `RX` with a frame of 8'h3C → `rx_valid=1` and `rx_data=8'h3C`. One `rx_rd` pulse → `rx_valid=0`.
- RX errors:
  - 40-cycle low glitch on `RX` → no push.
  - Frame of 8'h55 with stop bit 0 → no push.
  - 5 good frames of 8'h10..8'h14 without reads → FIFO holds 10,11,12,13; 14 is dropped.
- Simultaneous events: RX FIFO full while an `rx_rd` coincides with an RX push → count stays 4 and the new byte is appended.
- Reset mid-frame: assert PRESET during TX DATA and RX DATA → `TX=1` immediately. After release, `tx_busy=0`, `tx_empty=1`, `rx_valid=0`, and the next TX byte is sent cleanly.
